// File: rtl/hwag_coil_sched.sv
// Ignition coil scheduler: a single shared comparator visits every coil channel once per angle
// step. It drives dwell start and spark, reloads angles through shadow registers, and guards dwell length.
module hwag_coil_sched #(
  parameter int CHANNELS        = 4,
  parameter int ACNT_WIDTH      = 24,
  parameter int MAX_DWELL_STEPS = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hwag_start,
  input  logic [ACNT_WIDTH-1:0]       acnt,
  input  logic                        acnt_step,
  input  logic                        cfg_wr,
  input  logic [$clog2(CHANNELS)-1:0] cfg_ch,
  input  logic [ACNT_WIDTH-1:0]       cfg_set,
  input  logic [ACNT_WIDTH-1:0]       cfg_rst,
  input  logic                        fault_clr,
  output logic [CHANNELS-1:0]         pend_valid,
  output logic [CHANNELS-1:0]         coil_out,
  output logic                        busy,
  output logic                        overrun,
  output logic [CHANNELS-1:0]         fault
);
  localparam int IDX_W = $clog2(CHANNELS);
  localparam int DW    = $clog2(MAX_DWELL_STEPS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(CHANNELS - 1);
  localparam logic [DW-1:0]    DWELL_LIMIT = DW'(MAX_DWELL_STEPS);

  typedef enum logic {ST_IDLE, ST_CHARGING} ch_state_t;

  ch_state_t             r_state    [CHANNELS];
  logic [ACNT_WIDTH-1:0] r_act_set  [CHANNELS];
  logic [ACNT_WIDTH-1:0] r_act_rst  [CHANNELS];
  logic [ACNT_WIDTH-1:0] r_pend_set [CHANNELS];
  logic [ACNT_WIDTH-1:0] r_pend_rst [CHANNELS];
  logic [DW-1:0]         r_dwell    [CHANNELS];
  logic [CHANNELS-1:0]   r_pend_valid;
  logic [CHANNELS-1:0]   r_coil;
  logic [CHANNELS-1:0]   r_fault;
  logic                  r_busy;
  logic                  r_overrun;
  logic [IDX_W-1:0]      r_idx;
  logic [ACNT_WIDTH-1:0] r_acnt_q;

  logic          w_cfg_ok;
  logic          w_cfg_hit;
  logic          w_enabled;
  logic          w_set_hit;
  logic          w_rst_hit;
  logic          w_last;
  logic [DW-1:0] w_dwell_inc;

  // Out-of-range channel numbers only exist when CHANNELS is not a power of two.
  if ((1 << IDX_W) == CHANNELS) begin : g_ch_pow2
    assign w_cfg_ok = 1'b1;
  end else begin : g_ch_npow2
    assign w_cfg_ok = (cfg_ch <= LAST_IDX);
  end

  assign w_cfg_hit   = cfg_wr && w_cfg_ok;
  assign w_enabled   = (r_act_set[r_idx] != r_act_rst[r_idx]);
  assign w_set_hit   = (r_acnt_q == r_act_set[r_idx]);
  assign w_rst_hit   = (r_acnt_q == r_act_rst[r_idx]);
  assign w_last      = (r_idx == LAST_IDX);
  assign w_dwell_inc = r_dwell[r_idx] + DW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the angle arrays are reset too, since an all-zero set/reset pair is what marks a channel disabled.
      for (int k = 0; k < CHANNELS; k++) begin
        r_state[k]    <= ST_IDLE;
        r_act_set[k]  <= '0;
        r_act_rst[k]  <= '0;
        r_pend_set[k] <= '0;
        r_pend_rst[k] <= '0;
        r_dwell[k]    <= '0;
      end
      r_pend_valid <= '0;
      r_coil       <= '0;
      r_fault      <= '0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_idx        <= '0;
      r_acnt_q     <= '0;
    end else begin
      // NOTE: non-blocking updates let a transfer copy the old pending pair while a write in the same cycle replaces it.
      if (w_cfg_hit) begin
        r_pend_set[cfg_ch] <= cfg_set;
        r_pend_rst[cfg_ch] <= cfg_rst;
      end
      if (fault_clr) begin
        r_overrun <= 1'b0;
        r_fault   <= '0;
      end

      if (!hwag_start) begin
        for (int k = 0; k < CHANNELS; k++) begin
          r_state[k] <= ST_IDLE;
          r_dwell[k] <= '0;
        end
        r_coil <= '0;
        r_busy <= 1'b0;
        r_idx  <= '0;
      end else if (r_busy) begin
        if (acnt_step) r_overrun <= 1'b1;
        r_idx <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) r_busy <= 1'b0;

        case (r_state[r_idx])
          ST_IDLE: begin
            if (w_enabled && w_set_hit) begin
              r_state[r_idx] <= ST_CHARGING;
              r_coil[r_idx]  <= 1'b1;
              r_dwell[r_idx] <= '0;
            end else if (r_pend_valid[r_idx]) begin
              r_act_set[r_idx]    <= r_pend_set[r_idx];
              r_act_rst[r_idx]    <= r_pend_rst[r_idx];
              r_pend_valid[r_idx] <= 1'b0;
            end
          end
          ST_CHARGING: begin
            if (w_rst_hit) begin
              r_state[r_idx] <= ST_IDLE;
              r_coil[r_idx]  <= 1'b0;
            end else if (w_dwell_inc == DWELL_LIMIT) begin
              r_state[r_idx] <= ST_IDLE;
              r_coil[r_idx]  <= 1'b0;
              r_fault[r_idx] <= 1'b1;
            end else begin
              r_dwell[r_idx] <= w_dwell_inc;
            end
          end
        endcase
      end else if (acnt_step) begin
        r_acnt_q <= acnt;
        r_busy   <= 1'b1;
        r_idx    <= '0;
      end

      // A fresh write keeps pending valid even when its transfer happens this cycle.
      if (w_cfg_hit) r_pend_valid[cfg_ch] <= 1'b1;
    end
  end

  assign pend_valid = r_pend_valid;
  assign coil_out   = r_coil;
  assign busy       = r_busy;
  assign overrun    = r_overrun;
  assign fault      = r_fault;

endmodule
